boot_image_loader: RTL and testbench

Upstream front-end for the single-core memory model: it streams a program image, byte by byte, into memory over the look-ahead write port while the picorv32 core is held in reset. Once the image is in memory, it releases the core and passes the core's look-ahead bus straight through. This lets a bench load several assembled programs in turn into one running system without rebuilding it.

---
 rtl/boot_loader_pkg.sv | 27 ++
 rtl/byte_word_packer.sv | 33 +++
 rtl/boot_image_loader.sv | 148 ++++++++++++++
 tb/tb_boot_image_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot image loader.
// BOOT_CHECKSUM_EN adds the CHECK/ERR states and the trailing checksum byte.
package boot_loader_pkg;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [3:0] WSTRB_FULL     = 4'hF;
  localparam int         CSUM_W         = 8;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE,
    ERR
  } boot_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } boot_state_t;
`endif

endpackage

// File: rtl/byte_word_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// Latency: word valid the cycle after its 4th byte; no backpressure, caller gates i_vld.
module byte_word_packer
  import boot_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [1:0]  o_lane,
  output logic        o_word_done
);

  logic [31:0] r_word;
  logic [1:0]  r_lane;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_vld) begin
      r_word[{r_lane, 3'b000} +: 8] <= i_byte;
      r_lane                        <= r_lane + 2'd1;
    end
  end

  assign o_word      = r_word;
  assign o_lane      = r_lane;
  assign o_word_done = i_vld && (r_lane == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/boot_image_loader.sv
// Streams a byte image into memory over the look-ahead write port, then releases the core.
// Latency: 4 accept cycles + 1 write cycle per word; ld_ready drops during WRITE, stalls unbounded.
// Option: BOOT_CHECKSUM_EN appends a two's-complement checksum byte checked before release.
module boot_image_loader
  import boot_loader_pkg::*;
#(
  parameter logic [31:0] LOAD_BASE     = 32'h0000_0000,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_start,
  input  logic [15:0] ld_words,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_error,
  output logic        cpu_resetn,
  input  logic        cpu_la_read,
  input  logic        cpu_la_write,
  input  logic [31:0] cpu_la_addr,
  input  logic [31:0] cpu_la_wdata,
  input  logic [3:0]  cpu_la_wstrb,
  output logic        mem_la_read,
  output logic        mem_la_write,
  output logic [31:0] mem_la_addr,
  output logic [31:0] mem_la_wdata,
  output logic [3:0]  mem_la_wstrb,
  input  logic        mem_ready,
  output logic        cpu_mem_ready
);

  boot_state_t r_state, w_next;
  logic [15:0] r_cnt;
  logic [31:0] r_addr;
  logic [31:0] w_word;
  logic [1:0]  w_lane;
  logic        w_word_done;
  logic        w_pk_vld;
  logic        w_start_ok;
  logic        w_pass;
  boot_state_t w_empty_dest;
  boot_state_t w_last_dest;

  assign w_pk_vld = (r_state == RECV) && ld_valid;

`ifdef BOOT_CHECKSUM_EN
  logic [CSUM_W-1:0] r_sum;
  logic [CSUM_W-1:0] w_csum_exp;

  assign w_start_ok   = ld_start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_empty_dest = CHECK;
  assign w_last_dest  = CHECK;
  assign w_csum_exp   = ~r_sum + 8'd1;

  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_sum <= '0;
    end else if (w_pk_vld) begin
      r_sum <= r_sum + ld_data;
    end
  end
`else
  assign w_start_ok   = ld_start && (r_state == IDLE || r_state == DONE);
  assign w_empty_dest = DONE;
  assign w_last_dest  = DONE;
`endif

  // A partial word is dropped by clearing the packer on reset or a new start.
  byte_word_packer u_packer (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_clear     (w_start_ok),
    .i_vld       (w_pk_vld),
    .i_byte      (ld_data),
    .o_word      (w_word),
    .o_lane      (w_lane),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= LOAD_BASE;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_cnt  <= ld_words;
        r_addr <= LOAD_BASE;
      end else if (r_state == WRITE) begin
        r_cnt  <= r_cnt - 16'd1;
        r_addr <= r_addr + 32'd4;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_start_ok) begin
      w_next = (ld_words == 16'd0) ? w_empty_dest : RECV;
    end else begin
      unique case (r_state)
        RECV:    if (w_word_done) w_next = WRITE;
        WRITE:   w_next = (r_cnt == 16'd1) ? w_last_dest : RECV;
`ifdef BOOT_CHECKSUM_EN
        CHECK:   if (ld_valid) w_next = (ld_data == w_csum_exp) ? DONE : ERR;
        ERR:     w_next = ERR;
`endif
        IDLE:    w_next = IDLE;
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  assign w_pass = (r_state == DONE) || ((r_state == IDLE) && !HOLD_AT_RESET);

  always_comb begin
    ld_ready      = (r_state == RECV);
    ld_busy       = (r_state == RECV) || (r_state == WRITE);
    ld_done       = (r_state == DONE);
    ld_error      = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    ld_ready      = ld_ready || (r_state == CHECK);
    ld_busy       = ld_busy || (r_state == CHECK);
    ld_error      = (r_state == ERR);
`endif
    cpu_resetn    = w_pass;
    mem_la_read   = 1'b0;
    mem_la_write  = (r_state == WRITE);
    mem_la_addr   = r_addr;
    mem_la_wdata  = w_word;
    mem_la_wstrb  = (r_state == WRITE) ? WSTRB_FULL : 4'h0;
    cpu_mem_ready = 1'b0;
    if (w_pass) begin
      mem_la_read   = cpu_la_read;
      mem_la_write  = cpu_la_write;
      mem_la_addr   = cpu_la_addr;
      mem_la_wdata  = cpu_la_wdata;
      mem_la_wstrb  = cpu_la_wstrb;
      cpu_mem_ready = mem_ready;
    end
  end

endmodule

// File: tb/tb_boot_image_loader.sv
// Randomized bench for boot_image_loader: expected memory writes are queued by the
// stimulus from the byte image and popped by an independent write monitor.
module tb_boot_image_loader;

`ifdef BOOT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_start, ld_valid;
  logic [15:0] ld_words;
  logic [7:0]  ld_data;
  logic        ld_ready, ld_busy, ld_done, ld_error, cpu_resetn;
  logic        cpu_la_read, cpu_la_write;
  logic [31:0] cpu_la_addr, cpu_la_wdata;
  logic [3:0]  cpu_la_wstrb;
  logic        mem_la_read, mem_la_write;
  logic [31:0] mem_la_addr, mem_la_wdata;
  logic [3:0]  mem_la_wstrb;
  logic        mem_ready, cpu_mem_ready;

  always #5 clk = ~clk;

  boot_image_loader #(.LOAD_BASE(32'h0000_0000), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_words(ld_words),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_error(ld_error), .cpu_resetn(cpu_resetn),
    .cpu_la_read(cpu_la_read), .cpu_la_write(cpu_la_write), .cpu_la_addr(cpu_la_addr),
    .cpu_la_wdata(cpu_la_wdata), .cpu_la_wstrb(cpu_la_wstrb),
    .mem_la_read(mem_la_read), .mem_la_write(mem_la_write), .mem_la_addr(mem_la_addr),
    .mem_la_wdata(mem_la_wdata), .mem_la_wstrb(mem_la_wstrb),
    .mem_ready(mem_ready), .cpu_mem_ready(cpu_mem_ready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int  total = 0;
  int  bad   = 0;
  wr_t expq[$];
  bit  mon_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Every cycle with a loader write must match the oldest queued word.
  always @(negedge clk) begin
    if (mon_en && mem_la_write) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %h data %h expected no write", mem_la_addr, mem_la_wdata);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("write_addr", mem_la_addr, e.addr);
        chk("write_data", mem_la_wdata, e.data);
        chk("write_strb", {28'd0, mem_la_wstrb}, 32'hF);
      end
    end
  end

  task automatic start(input int n);
    ld_start = 1'b1;
    ld_words = 16'(n);
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall_max);
    int  st;
    bit  rdy;
    bit  took;
    st = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
    ld_valid = 1'b0;
    repeat (st) begin @(posedge clk); #1; end
    ld_valid = 1'b1;
    ld_data  = b;
    took     = 1'b0;
    for (int t = 0; t < 50 && !took; t++) begin
      @(negedge clk);
      rdy = ld_ready;
      @(posedge clk); #1;
      took = rdy;
    end
    if (!took) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: byte %h never accepted, expected acceptance", b);
    end
    ld_valid = 1'b0;
  endtask

  // Full load: start, stream image (plus checksum when enabled), verify final status.
  task automatic do_load(input logic [7:0] img[$], input int stall, input logic [7:0] csum_ofs);
    int          n;
    bit          exp_busy, exp_ok;
    logic [7:0]  s;
    logic [7:0]  cb;
    logic [31:0] w;
    wr_t         e;
    n        = img.size() / 4;
    s        = 8'd0;
    exp_busy = (n > 0) || CSUM;
    exp_ok   = !CSUM || (csum_ofs == 8'd0);
    start(n);
    @(negedge clk);
    chk1("busy_after_start", ld_busy, exp_busy);
    chk1("resetn_after_start", cpu_resetn, !exp_busy);
    chk1("done_after_start", ld_done, !exp_busy);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++) begin
        send_byte(img[4*k+j], stall);
        w[8*j +: 8] = img[4*k+j];
        s = s + img[4*k+j];
      end
      e.addr = 32'(4 * k);
      e.data = w;
      expq.push_back(e);
    end
    if (n > 0) begin @(posedge clk); #1; end
    if (CSUM) begin
      cb = ~s + 8'd1 + csum_ofs;
      send_byte(cb, stall);
    end
    @(negedge clk);
    chk1("ld_done", ld_done, exp_ok);
    chk1("ld_error", ld_error, !exp_ok);
    chk1("cpu_resetn", cpu_resetn, exp_ok);
    chk1("busy_end", ld_busy, 1'b0);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rand_img(input int n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  img[$];
    logic [31:0] a, d;
    wr_t         e;
    reset = 1'b1; ld_start = 1'b0; ld_words = 16'd0; ld_valid = 1'b0; ld_data = 8'd0;
    cpu_la_read = 1'b1; cpu_la_write = 1'b1; cpu_la_addr = 32'h100;
    cpu_la_wdata = 32'h1234; cpu_la_wstrb = 4'hF; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_cpu_resetn", cpu_resetn, 1'b0);
    chk1("rst_mem_write", mem_la_write, 1'b0);
    chk1("rst_mem_read", mem_la_read, 1'b0);
    chk1("rst_ld_ready", ld_ready, 1'b0);
    chk1("rst_ld_busy", ld_busy, 1'b0);
    chk1("rst_ld_done", ld_done, 1'b0);
    chk1("rst_ld_error", ld_error, 1'b0);
    chk1("rst_cpu_mem_ready", cpu_mem_ready, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("idle_blocks_cpu_write", mem_la_write, 1'b0);
    cpu_la_read = 1'b0; cpu_la_write = 1'b0;
    @(posedge clk); #1;

    img = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(img, 0, 8'd0);
    do_load(img, 4, 8'd0);

    // Pass-through once the core is released.
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; d = $urandom;
      cpu_la_addr = a; cpu_la_wdata = d; cpu_la_wstrb = 4'(i + 3);
      cpu_la_write = i[0]; cpu_la_read = !i[0]; mem_ready = i[1];
      @(negedge clk);
      chk("pt_addr", mem_la_addr, a);
      chk("pt_wdata", mem_la_wdata, d);
      chk("pt_wstrb", {28'd0, mem_la_wstrb}, 32'(i + 3));
      chk1("pt_write", mem_la_write, i[0]);
      chk1("pt_read", mem_la_read, !i[0]);
      chk1("pt_ready", cpu_mem_ready, i[1]);
      @(posedge clk); #1;
    end
    cpu_la_read = 1'b0; cpu_la_write = 1'b0; mem_ready = 1'b1;
    mon_en = 1'b1;

    img = {};
    do_load(img, 0, 8'd0);

    if (CSUM) begin
      img = '{8'h01, 8'h02, 8'h03, 8'h04};
      do_load(img, 0, 8'd0);
      do_load(img, 2, 8'hFF);
    end

    // Reset after two bytes of the second word: only word 0 reaches memory.
    start(2);
    @(posedge clk); #1;
    img = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    foreach (img[i]) send_byte(img[i], 1);
    e.addr = 32'h0; e.data = 32'hAABBCCDD;
    expq.push_back(e);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("midrst_busy", ld_busy, 1'b0);
    chk1("midrst_ready", ld_ready, 1'b0);
    chk1("midrst_done", ld_done, 1'b0);
    chk1("midrst_resetn", cpu_resetn, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_word0_written", 32'(expq.size()), 32'd0);

    for (int r = 0; r < 5; r++) begin
      rand_img(int'($urandom_range(5, 1)), img);
      do_load(img, r % 4, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
